// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: command FSM, seconds prescaler and minutes counter driving an external mod-60 seconds counter.
// Latency: a command acts on the first clk edge that samples its input high; sec_en/sec_clr are registered one-cycle pulses.
// No backpressure: command inputs are debounced levels, and an optional lap display is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       reset_req,
  input  logic [5:0] sec_count,
  input  logic       sec_rollover,
  output logic       sec_en,
  output logic       sec_clr,
  output logic [5:0] min_count,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [1:0] state
);

  // Prescaler wide enough to hold CLK_DIV-1; CLK_DIV is at least 2, so one bit is the floor.
  localparam int unsigned   PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_LAP   = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic          start_prev_q, start_prev_d;
  logic          lap_prev_q, lap_prev_d;
  logic          reset_prev_q, reset_prev_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          sec_en_q, sec_en_d;
  logic          sec_clr_q, sec_clr_d;
  logic [5:0]    min_q, min_d;

  logic          start_edge;
  logic          clr_cmd;
  logic          start_cmd;
  logic          lap_cmd;
  logic          running;
  logic          pause_to_idle;

  // Rising-edge detection and command arbitration: reset_req beats start_stop beats lap.
  always_comb begin
    start_prev_d = start_stop;
    lap_prev_d   = lap;
    reset_prev_d = reset_req;
    start_edge   = start_stop & ~start_prev_q;
    clr_cmd      = reset_req & ~reset_prev_q;
    start_cmd    = start_edge & ~clr_cmd;
    lap_cmd      = lap & ~lap_prev_q & ~clr_cmd & ~start_edge;
  end

  // Edge-detect history; cleared in reset so a level already high at release counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev_q <= 1'b0;
      lap_prev_q   <= 1'b0;
      reset_prev_q <= 1'b0;
    end else begin
      start_prev_q <= start_prev_d;
      lap_prev_q   <= lap_prev_d;
      reset_prev_q <= reset_prev_d;
    end
  end

  // Next-state logic; any command not listed for a state is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_cmd) state_d = S_RUN;
      end
      S_RUN: begin
        if (start_cmd) state_d = S_PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap_cmd) state_d = S_LAP;
`endif
      end
`ifdef STOPWATCH_LAP_EN
      S_LAP: begin
        if (start_cmd)    state_d = S_PAUSE;
        else if (lap_cmd) state_d = S_RUN;
      end
`endif
      S_PAUSE: begin
        if (clr_cmd)        state_d = S_IDLE;
        else if (start_cmd) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Prescaler, sec_en/sec_clr pulses and minutes counter.
  // The prescaler advances only on cycles spent in RUN/LAP and holds through PAUSE, so the
  // fractional second survives a pause and every second is exactly CLK_DIV enabled cycles.
  always_comb begin
    running       = (state_q == S_RUN) || (state_q == S_LAP);
    pause_to_idle = (state_q == S_PAUSE) && clr_cmd;

    pre_d = pre_q;
    if (running) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
    end
    if (pause_to_idle) begin
      pre_d = '0;
    end

    sec_en_d  = running && (pre_q == PRE_MAX);
    sec_clr_d = pause_to_idle;

    // Rollover can arrive in PAUSE when the last enabled cycle completed a second; still count it.
    min_d = min_q;
    if (sec_rollover) begin
      min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end
    if (pause_to_idle) begin
      min_d = 6'd0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      sec_en_q  <= 1'b0;
      sec_clr_q <= 1'b0;
      min_q     <= 6'd0;
    end else begin
      pre_q     <= pre_d;
      sec_en_q  <= sec_en_d;
      sec_clr_q <= sec_clr_d;
      min_q     <= min_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [5:0] lap_sec_q, lap_sec_d;
  logic [5:0] lap_min_q, lap_min_d;

  // Lap capture on RUN->LAP; min_q is the pre-increment value even when a rollover lands on the same edge.
  always_comb begin
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    if ((state_q == S_RUN) && (state_d == S_LAP)) begin
      lap_sec_d = sec_count;
      lap_min_d = min_q;
    end
  end

  // Lap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_sec_q <= 6'd0;
      lap_min_q <= 6'd0;
    end else begin
      lap_sec_q <= lap_sec_d;
      lap_min_q <= lap_min_d;
    end
  end

  // Frozen lap values while in LAP, live values otherwise (live again the cycle LAP is left).
  always_comb begin
    disp_sec = sec_count;
    disp_min = min_q;
    if (state_q == S_LAP) begin
      disp_sec = lap_sec_q;
      disp_min = lap_min_q;
    end
  end
`else
  // Without the lap feature lap edges are decoded but never consumed.
  logic unused_lap_cmd;
  assign unused_lap_cmd = lap_cmd;

  assign disp_sec = sec_count;
  assign disp_min = min_q;
`endif

  assign sec_en    = sec_en_q;
  assign sec_clr   = sec_clr_q;
  assign min_count = min_q;
  assign state     = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000000, clk cycles per second tick (legal range 2..2^26).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_stop  input  1  synchronous debounced level; a rising edge is a start/stop command.
REQ-005 SHALL have port lap  input  1  synchronous debounced level; a rising edge is a lap command.
REQ-006 SHALL have port reset_req  input  1  synchronous debounced level; a rising edge is a clear command.
REQ-007 SHALL have port sec_count  input  6  live count from the external mod-60 seconds counter.
REQ-008 SHALL have port sec_rollover  input  1  59->0 wrap pulse from the seconds counter.
REQ-009 SHALL have port sec_en  output  1  one-cycle count-enable pulse to the seconds counter.
REQ-010 SHALL have port sec_clr  output  1  one-cycle synchronous clear to the seconds counter.
REQ-011 SHALL have port min_count  output  6  minutes, 0..59.
REQ-012 SHALL have ports disp_sec and disp_min  output  6 each  display values.
REQ-013 SHALL have port state  output  2  FSM state encoding, IDLE=00, RUN=01, LAP=10, PAUSE=11.

Function
REQ-014 SHALL detect each command as in & ~in_d, with in_d a registered copy of the input, so the state changes at the first clk edge where the input is sampled high.
REQ-015 SHALL resolve simultaneous command edges in priority reset_req > start_stop > lap; lower-priority edges in the same cycle are dropped.
REQ-016 SHALL make FSM transitions IDLE-start->RUN, RUN-start->PAUSE, RUN-lap->LAP, LAP-lap->RUN, LAP-start->PAUSE, PAUSE-start->RUN, PAUSE-reset->IDLE; every other command in every state is ignored.
REQ-017 SHALL run a prescaler 0..CLK_DIV-1 only in RUN or LAP; it wraps to 0 after CLK_DIV-1, holds its value in PAUSE, and is 0 in IDLE.
REQ-018 SHALL assert sec_en for exactly one cycle when the prescaler equals CLK_DIV-1 in RUN or LAP, so the first pulse follows the IDLE->RUN transition by exactly CLK_DIV cycles.
REQ-019 SHALL preserve the fractional second over PAUSE->RUN, so total enabled cycles between sec_en pulses is always CLK_DIV.
REQ-020 SHALL increment min_count on the cycle after sec_rollover is sampled high, wrapping 59->0.
REQ-021 SHALL, on PAUSE->IDLE, pulse sec_clr for one cycle and zero min_count and the prescaler at the same edge.
REQ-022 SHALL drive disp_sec/disp_min equal to sec_count/min_count in IDLE, RUN and PAUSE.
REQ-023 SHALL, on RUN->LAP, capture sec_count and min_count into lap registers and drive the display from them for the whole LAP state, while counting continues.
REQ-024 SHALL restore the live display on the cycle after leaving LAP.
REQ-025 SHALL treat a lap edge in the same cycle as a sec_rollover so that the captured minutes are the pre-increment value.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, prescaler=0, min_count=0, lap registers=0, sec_en=0, sec_clr=0, and all edge-detect registers=0.
REQ-027 SHALL treat an input already high when rst_n deasserts as a command edge on the first clock.
REQ-028 SHALL abandon a reset asserted mid-RUN entirely, with no sec_clr pulse generated; the external counter is expected to share rst_n.

Configuration
REQ-029 SHALL, when macro STOPWATCH_LAP_EN is defined, implement the LAP state, lap registers and REQ-023..025.
REQ-030 SHALL, when STOPWATCH_LAP_EN is undefined, omit the LAP state and lap registers, ignore lap edges, and keep the display always live; state never reads 10.

Verification (CLK_DIV=4, STOPWATCH_LAP_EN defined)
REQ-031 SHALL check: start edge from IDLE -> state=01 next cycle; sec_en pulses every 4 cycles with the first 4 cycles after the transition; sec_count 0->1->2.
REQ-032 SHALL check: run to sec_count=59 with one more sec_en -> sec_rollover observed, min_count 0->1, sec_count=0.
REQ-033 SHALL check: start edge 2 cycles after a sec_en -> PAUSE with no sec_en; resume -> next sec_en exactly 2 enabled cycles later.
REQ-034 SHALL check: lap at sec=5,min=1 -> disp frozen at 5/1 while sec_count reaches 8; lap again -> disp=8/1 next cycle.
REQ-035 SHALL check: reset_req and start_stop rising together in PAUSE -> IDLE, one-cycle sec_clr, min_count=0.
REQ-036 SHALL check: rst_n low mid-RUN at min=3 -> all outputs zero asynchronously and state=00.
